idu_pipe: RTL and testbench

- Registered, parametrised RV32I/RV64I instruction-decode stage for the NPC pipeline; sits between IFU and EXU.
- Accepts {pc, instr} over a valid/ready handshake and decodes register indices, immediate, format and illegal flag.
- Holds one decoded entry in an output pipeline register.
- Inserts load-use stall bubbles and supports a synchronous flush from branch/exception redirect.

---
 rtl/idu_pipe_if.sv | 36 +++
 rtl/idu_pipe.sv | 124 ++++++++++++
 tb/tb_idu_pipe.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/idu_pipe_if.sv
// idu_pipe_if: IFU -> IDU -> EXU handshake and decoded-entry bundle.
interface idu_pipe_if #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [PC_W-1:0] in_pc;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [31:0]     out_instr;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_rs1_used;
    logic            out_rs2_used;
    logic            out_is_load;
    logic            out_illegal;

    modport slave (
        input  flush, in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_rs1, out_rs2, out_rd,
               out_imm, out_fmt, out_rs1_used, out_rs2_used, out_is_load, out_illegal
    );

    modport master (
        output flush, in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_rs1, out_rs2, out_rd,
               out_imm, out_fmt, out_rs1_used, out_rs2_used, out_is_load, out_illegal
    );
endinterface

// File: rtl/idu_pipe.sv
// idu_pipe: registered RV32I/RV64I decode stage with load-use interlock and flush.
module idu_pipe #(
    parameter int XLEN     = 32,
    parameter int PC_W     = 32,
    parameter int LU_STALL = 1
) (
    input logic       clk,
    input logic       rst_n,
    idu_pipe_if.slave bus
);
    localparam int CW = (LU_STALL < 1) ? 1 : $clog2(LU_STALL + 1);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;

    logic [31:0]     w_ins;
    logic [6:0]      w_op;
    logic            w_is_r, w_is_i, w_is_s, w_is_b, w_is_u, w_is_j, w_ill;
    logic [2:0]      w_fmt;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic            w_rs1_used, w_rs2_used, w_hazard, w_in, w_out;

    logic            r_valid;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_imm;
    logic [2:0]      r_fmt;
    logic            r_rs1_used, r_rs2_used, r_is_load, r_illegal;
    logic [CW-1:0]   r_cnt;
    logic [4:0]      r_ld_rd;

    assign w_ins = bus.in_instr;

    always_comb begin
        w_op       = w_ins[6:0];
        w_is_r     = (w_op == OP_OP) || ((XLEN == 64) && (w_op == OP_OP32));
        w_is_i     = (w_op == OP_IMM) || (w_op == OP_LOAD) || (w_op == OP_JALR) ||
                     (w_op == OP_SYSTEM) || ((XLEN == 64) && (w_op == OP_IMM32));
        w_is_s     = w_op == OP_STORE;
        w_is_b     = w_op == OP_BRANCH;
        w_is_u     = (w_op == OP_LUI) || (w_op == OP_AUIPC);
        w_is_j     = w_op == OP_JAL;
        w_ill      = ~(w_is_r | w_is_i | w_is_s | w_is_b | w_is_u | w_is_j);
        w_fmt      = w_is_r ? 3'd0 : w_is_s ? 3'd2 : w_is_b ? 3'd3 :
                     w_is_u ? 3'd4 : w_is_j ? 3'd5 : 3'd1;
        w_imm32    = (w_fmt == 3'd0) ? 32'd0 :
                     (w_fmt == 3'd2) ? {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]} :
                     (w_fmt == 3'd3) ? {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0} :
                     (w_fmt == 3'd4) ? {w_ins[31:12], 12'd0} :
                     (w_fmt == 3'd5) ? {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0} :
                                       {{20{w_ins[31]}}, w_ins[31:20]};
        w_imm      = XLEN'($signed(w_imm32));
        w_rs1_used = w_fmt <= 3'd3;
        w_rs2_used = (w_fmt == 3'd0) || (w_fmt == 3'd2) || (w_fmt == 3'd3);
        // Hazard is judged on the instruction being offered, not the one held.
        w_hazard   = (r_cnt != '0) & bus.in_valid &
                     ((w_rs1_used & (w_ins[19:15] == r_ld_rd)) | (w_rs2_used & (w_ins[24:20] == r_ld_rd)));
        bus.in_ready = rst_n & ~w_hazard & (~r_valid | bus.out_ready);
        w_in       = bus.in_valid & bus.in_ready & ~bus.flush;
        w_out      = r_valid & bus.out_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_instr    <= '0;
            r_imm      <= '0;
            r_fmt      <= '0;
            r_rs1_used <= 1'b0;
            r_rs2_used <= 1'b0;
            r_is_load  <= 1'b0;
            r_illegal  <= 1'b0;
            r_cnt      <= '0;
            r_ld_rd    <= '0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_in) begin
                r_valid    <= 1'b1;
                r_pc       <= bus.in_pc;
                r_instr    <= w_ins;
                r_imm      <= w_imm;
                r_fmt      <= w_fmt;
                r_rs1_used <= w_rs1_used;
                r_rs2_used <= w_rs2_used;
                r_is_load  <= w_op == OP_LOAD;
                r_illegal  <= w_ill;
            end else if (w_out) begin
                r_valid <= 1'b0;
            end
            if (w_out && r_is_load && (r_instr[11:7] != 5'd0)) begin
                r_cnt   <= CW'(LU_STALL);
                r_ld_rd <= r_instr[11:7];
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    assign bus.out_valid    = r_valid;
    assign bus.out_pc       = r_pc;
    assign bus.out_instr    = r_instr;
    assign bus.out_rs1      = r_instr[19:15];
    assign bus.out_rs2      = r_instr[24:20];
    assign bus.out_rd       = r_instr[11:7];
    assign bus.out_imm      = r_imm;
    assign bus.out_fmt      = r_fmt;
    assign bus.out_rs1_used = r_rs1_used;
    assign bus.out_rs2_used = r_rs2_used;
    assign bus.out_is_load  = r_is_load;
    assign bus.out_illegal  = r_illegal;
endmodule

// File: tb/tb_idu_pipe.sv
// tb_idu_pipe: scoreboard bench driving an RV32 and an RV64 instance with identical stimulus.
module tb_idu_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic [31:0] pcv = 32'h100;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        u1, u2, ld, ill32, ill64;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    idu_pipe_if #(.XLEN(32), .PC_W(32)) b32 ();
    idu_pipe_if #(.XLEN(64), .PC_W(32)) b64 ();

    assign b32.flush = flush;
    assign b32.in_valid = in_valid;
    assign b32.in_pc = in_pc;
    assign b32.in_instr = in_instr;
    assign b32.out_ready = out_ready;
    assign b64.flush = flush;
    assign b64.in_valid = in_valid;
    assign b64.in_pc = in_pc;
    assign b64.in_instr = in_instr;
    assign b64.out_ready = out_ready;

    idu_pipe #(.XLEN(32), .PC_W(32), .LU_STALL(1)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
    idu_pipe #(.XLEN(64), .PC_W(32), .LU_STALL(1)) u64 (.clk(clk), .rst_n(rst_n), .bus(b64.slave));

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic cmp(input string t, input exp_t e, input logic [31:0] pc, input logic [31:0] ins,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [63:0] imm, input logic [63:0] eimm, input logic [2:0] fmt,
                       input logic u1, input logic u2, input logic ld, input logic ill, input logic eill);
        logic [31:0] w;
        w = e.instr;
        chk({t, " pc"}, 64'(pc), 64'(e.pc));
        chk({t, " instr"}, 64'(ins), 64'(w));
        chk({t, " rs1"}, 64'(rs1), 64'(w[19:15]));
        chk({t, " rs2"}, 64'(rs2), 64'(w[24:20]));
        chk({t, " rd"}, 64'(rd), 64'(w[11:7]));
        chk({t, " imm"}, imm, eimm);
        chk({t, " fmt"}, 64'(fmt), 64'(e.fmt));
        chk({t, " rs1_used"}, 64'(u1), 64'(e.u1));
        chk({t, " rs2_used"}, 64'(u2), 64'(e.u2));
        chk({t, " is_load"}, 64'(ld), 64'(e.ld));
        chk({t, " illegal"}, 64'(ill), 64'(eill));
    endtask

    // Monitor: every cycle an entry is presented it must equal the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (b32.out_valid) begin
                if (q32.size() == 0) chk("d32 unexpected out_valid", 64'd1, 64'd0);
                else begin
                    cmp("d32", q32[0], b32.out_pc, b32.out_instr, b32.out_rs1, b32.out_rs2, b32.out_rd,
                        64'(b32.out_imm), {32'd0, q32[0].imm[31:0]}, b32.out_fmt, b32.out_rs1_used,
                        b32.out_rs2_used, b32.out_is_load, b32.out_illegal, q32[0].ill32);
                    if (out_ready) void'(q32.pop_front());
                end
            end
            if (b64.out_valid) begin
                if (q64.size() == 0) chk("d64 unexpected out_valid", 64'd1, 64'd0);
                else begin
                    cmp("d64", q64[0], b64.out_pc, b64.out_instr, b64.out_rs1, b64.out_rs2, b64.out_rd,
                        b64.out_imm, q64[0].imm, b64.out_fmt, b64.out_rs1_used,
                        b64.out_rs2_used, b64.out_is_load, b64.out_illegal, q64[0].ill64);
                    if (out_ready) void'(q64.pop_front());
                end
            end
        end
    end

    function automatic exp_t mk(input logic [31:0] ins, input logic [63:0] imm, input logic [2:0] fmt,
                                input logic u1, input logic u2, input logic ld, input logic i32, input logic i64);
        exp_t e;
        e.pc = '0;
        e.instr = ins;
        e.imm = imm;
        e.fmt = fmt;
        e.u1 = u1;
        e.u2 = u2;
        e.ld = ld;
        e.ill32 = i32;
        e.ill64 = i64;
        return e;
    endfunction

    // Offer e until accepted; leaves in_valid high, returns one cycle after the accepting edge.
    task automatic send(input exp_t e, output int acc);
        bit ok;
        ok = 1'b0;
        acc = -1;
        in_valid = 1'b1;
        in_instr = e.instr;
        in_pc = pcv;
        e.pc = pcv;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk); #1;
            if (b32.in_ready && !flush) begin
                ok = 1'b1;
                acc = cyc;
                q32.push_back(e);
                q64.push_back(e);
                pcv = pcv + 32'd4;
            end
            @(posedge clk); #1;
        end
        if (!ok) chk("accept timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic lu(input exp_t ld, input exp_t nx, input int d, input string nm);
        int a, t0;
        send(ld, a);
        idle(1);
        t0 = cyc;
        send(nx, a);
        chk(nm, 64'(a - t0), 64'(d));
        idle(3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e_addi, e_jal, e_sw, e_beq, e_lui, e_lw6, e_dep, e_ind, e_lw0, e_addiw, e_zero, e_luin;
        int a0, a1, a2, r, t0;
        e_addi  = mk(32'hFFF00293, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1, 0, 0, 0, 0);
        e_jal   = mk(32'h008000EF, 64'd8, 3'd5, 0, 0, 0, 0, 0);
        e_sw    = mk(32'h00112623, 64'd12, 3'd2, 1, 1, 0, 0, 0);
        e_beq   = mk(32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1, 1, 0, 0, 0);
        e_lui   = mk(32'h12345537, 64'h0000_0000_1234_5000, 3'd4, 0, 0, 0, 0, 0);
        e_lw6   = mk(32'h0000A303, 64'd0, 3'd1, 1, 0, 1, 0, 0);
        e_dep   = mk(32'h002303B3, 64'd0, 3'd0, 1, 1, 0, 0, 0);
        e_ind   = mk(32'h002183B3, 64'd0, 3'd0, 1, 1, 0, 0, 0);
        e_lw0   = mk(32'h0000A003, 64'd0, 3'd1, 1, 0, 1, 0, 0);
        e_addiw = mk(32'h0010009B, 64'd1, 3'd1, 1, 0, 0, 1, 0);
        e_zero  = mk(32'h00000000, 64'd0, 3'd1, 1, 0, 0, 1, 1);
        e_luin  = mk(32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst out_valid", 64'(b32.out_valid), 64'd0);
        chk("rst out_pc", 64'(b32.out_pc), 64'd0);
        chk("rst out_instr", 64'(b64.out_instr), 64'd0);
        chk("rst out_imm", b64.out_imm, 64'd0);
        chk("rst in_ready", 64'(b32.in_ready), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("idle in_ready", 64'(b32.in_ready), 64'd1);
        @(posedge clk); #1;

        send(e_addi, a0);
        chk("latency out_valid", 64'(b32.out_valid), 64'd1);
        idle(2);

        send(e_jal, a0);
        send(e_sw, a1);
        send(e_beq, a2);
        chk("b2b gap jal-sw", 64'(a1 - a0), 64'd1);
        chk("b2b gap sw-beq", 64'(a2 - a1), 64'd1);
        idle(2);

        out_ready = 1'b0;
        send(e_lui, a0);
        in_instr = e_ind.instr;
        in_pc = pcv;
        repeat (3) begin
            @(negedge clk); #1;
            chk("hold in_ready", 64'(b32.in_ready), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        r = cyc;
        send(e_ind, a0);
        chk("release accept cycle", 64'(a0), 64'(r));
        idle(3);

        lu(e_lw6, e_dep, 1, "load-use stall");
        lu(e_lw6, e_ind, 0, "independent no stall");
        lu(e_lw0, e_dep, 0, "x0 load no stall");

        send(e_lw6, a0);
        send(e_ind, a1);
        flush = 1'b1;
        in_instr = e_addi.instr;
        in_pc = pcv;
        @(negedge clk); #1;
        chk("flush in_ready", 64'(b32.in_ready), 64'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush out_valid", 64'(b32.out_valid), 64'd0);
        t0 = cyc;
        send(e_dep, a0);
        chk("post-flush accept", 64'(a0 - t0), 64'd0);
        idle(3);

        send(e_addiw, a0);
        send(e_zero, a0);
        send(e_luin, a0);
        idle(4);

        chk("q32 drained", 64'(q32.size()), 64'd0);
        chk("q64 drained", 64'(q64.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
